// File: rtl/pulse_generator_pkg.sv
// -----------------------------------------------------------------------------
// pulse_generator_pkg
// Shared definitions for the heartbeat/code pulse transmitter. The state
// encoding lives here, not inside the transmitter, so that pulse_detection
// and command can name the same states and burst-length width.
// -----------------------------------------------------------------------------
package pulse_generator_pkg;

  // State encoding, visible by name to neighbouring blocks.
  localparam logic [1:0] PG_ST_IDLE  = 2'd0;
  localparam logic [1:0] PG_ST_HEART = 2'd1;
  localparam logic [1:0] PG_ST_BURST = 2'd2;
  localparam logic [1:0] PG_ST_GAP   = 2'd3;

  // Width of the burst code length (0..15 pulses).
  localparam int BURST_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = PG_ST_IDLE,
    ST_HEART = PG_ST_HEART,
    ST_BURST = PG_ST_BURST,
    ST_GAP   = PG_ST_GAP
  } pg_state_e;

  // The transmitter is busy while a code burst or its trailing gap is
  // in progress.
  function automatic logic state_busy(input pg_state_e s);
    return (s == ST_BURST) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/pulse_generator.sv
// -----------------------------------------------------------------------------
// pulse_generator
// Heartbeat/code pulse transmitter for one CPU channel. While enabled it
// emits a continuous PERIOD-cycle square wave with HIGH cycles high. On a
// burst_req/burst_ack handshake it sends burst_len full-period pulses that
// encode a status code, followed by GAP silent cycles.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous, active-low reset
//   enable     in   level; heartbeat runs while high
//   burst_req  in   level; held high by the requester until burst_ack
//   burst_len  in   number of code pulses, sampled on the acceptance cycle
//   burst_ack  out  one-cycle strobe on burst acceptance
//   busy       out  high while a burst or its gap is in progress
//   pulse      out  registered line output
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | line low, waiting for enable or a burst request
// HEART  | free-running heartbeat, cnt runs 0..PERIOD-1
// BURST  | code pulses, pcnt holds pulses still to send
// GAP    | line low for GAP cycles after a burst, cnt runs 0..GAP-1
// -----------------------------------------------------------------------------
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int PERIOD = 50000,
  parameter int HIGH   = 25000,
  parameter int GAP    = 200000,
  parameter int CNT_W  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   burst_req,
  input  logic [BURST_LEN_W-1:0] burst_len,
  output logic                   burst_ack,
  output logic                   busy,
  output logic                   pulse
);

  localparam logic [CNT_W-1:0]       C_PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]       C_GAP_LAST    = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0]       C_HIGH        = CNT_W'(HIGH);
  localparam logic [CNT_W-1:0]       C_CNT_ONE     = CNT_W'(1);
  localparam logic [BURST_LEN_W-1:0] C_PCNT_ONE    = BURST_LEN_W'(1);

  pg_state_e              r_state;
  pg_state_e              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [BURST_LEN_W-1:0] r_pcnt;
  logic [BURST_LEN_W-1:0] w_pcnt_nxt;

  logic r_pulse;
  logic r_ack;
  logic r_busy;
  logic w_pulse_nxt;
  logic w_ack_nxt;
  logic w_busy_nxt;

  logic w_period_wrap;
  logic w_gap_wrap;
  logic w_accept;

  assign w_period_wrap = (r_cnt == C_PERIOD_LAST);
  assign w_gap_wrap    = (r_cnt == C_GAP_LAST);

  // Requests are only taken from IDLE or at a heartbeat period boundary,
  // so an accepted burst never truncates a heartbeat pulse.
  assign w_accept = burst_req &&
                    ((r_state == ST_IDLE) ||
                     ((r_state == ST_HEART) && w_period_wrap));

  // ---------------------------------------------------------------------------
  // Next-state, counter and pulse-count logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pcnt_nxt  = r_pcnt;
    w_ack_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (enable) begin
          w_state_nxt = ST_HEART;
        end
      end

      ST_HEART: begin
        if (w_period_wrap) begin
          w_cnt_nxt = '0;
          if (!enable) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      ST_BURST: begin
        if (w_period_wrap) begin
          w_cnt_nxt = '0;
          // pcnt is never 0 here (zero-length bursts skip BURST), but
          // treating <=1 as last keeps a corrupted count from looping.
          if (r_pcnt <= C_PCNT_ONE) begin
            w_pcnt_nxt  = '0;
            w_state_nxt = ST_GAP;
          end else begin
            w_pcnt_nxt = r_pcnt - C_PCNT_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      ST_GAP: begin
        if (w_gap_wrap) begin
          w_cnt_nxt   = '0;
          // A request still pending here waits for the next IDLE or
          // heartbeat wrap; that gives the requester GAP cycles to drop it.
          w_state_nxt = enable ? ST_HEART : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_pcnt_nxt  = '0;
      end
    endcase

    // Acceptance overrides the plain transitions above and restarts the
    // period so the first code pulse starts high on the acceptance edge.
    if (w_accept) begin
      w_ack_nxt   = 1'b1;
      w_cnt_nxt   = '0;
      w_pcnt_nxt  = burst_len;
      w_state_nxt = (burst_len == '0) ? ST_GAP : ST_BURST;
    end
  end

  // Outputs are derived from the next state/count so the registered line
  // lines up with the counter it belongs to.
  always_comb begin
    w_pulse_nxt = 1'b0;
    if ((w_state_nxt == ST_HEART) || (w_state_nxt == ST_BURST)) begin
      w_pulse_nxt = (w_cnt_nxt < C_HIGH);
    end
    w_busy_nxt = state_busy(w_state_nxt);
  end

  // ---------------------------------------------------------------------------
  // FSM and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered output stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pulse <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_pulse <= w_pulse_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign pulse     = r_pulse;
  assign burst_ack = r_ack;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pulse_generator.sv
module tb_pulse_generator;

  localparam int P = 10;
  localparam int H = 4;
  localparam int G = 20;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       enable    = 1'b0;
  logic       burst_req = 1'b0;
  logic [3:0] burst_len = 4'd0;
  logic       burst_ack;
  logic       busy;
  logic       pulse;

  int n_vec = 0;
  int n_err = 0;

  pulse_generator #(.PERIOD(P), .HIGH(H), .GAP(G), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .burst_req(burst_req),
    .burst_len(burst_len),
    .burst_ack(burst_ack),
    .busy     (busy),
    .pulse    (pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    burst_req = 1'b0;
    burst_len = 4'd0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: one row per clock, outputs expected after the edge
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst_n;
    logic       en;
    logic       req;
    logic [3:0] len;
    logic       p;
    logic       a;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input logic q, input logic [3:0] l,
                              input logic p, input logic a, input logic b);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = q; v.len = l;
    v.p = p; v.a = a; v.b = b;
    tbl.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: heartbeat as a phase counter, bursts as a pre-computed
  // per-cycle schedule of line values played back from a queue.
  // ---------------------------------------------------------------------------
  bit m_q[$];
  bit m_in_burst = 1'b0;
  int m_hb       = -1;
  bit m_p = 1'b0, m_a = 1'b0, m_b = 1'b0;

  function automatic void model_accept(input logic [3:0] len);
    int n;
    n = int'(len) * P;
    m_q.delete();
    for (int k = 0; k < n + G; k++) m_q.push_back((k < n) && ((k % P) < H));
    m_in_burst = 1'b1;
    m_hb       = -1;
    m_a        = 1'b1;
    m_b        = 1'b1;
    m_p        = m_q.pop_front();
  endfunction

  function automatic void model_step(input logic r, input logic en, input logic rq, input logic [3:0] len);
    m_a = 1'b0;
    if (!r) begin
      m_q.delete();
      m_in_burst = 1'b0;
      m_hb = -1; m_p = 1'b0; m_b = 1'b0;
      return;
    end
    if (m_in_burst) begin
      if (m_q.size() > 0) begin
        m_p = m_q.pop_front();
        m_b = 1'b1;
      end else begin
        m_in_burst = 1'b0;
        m_b = 1'b0;
        if (en) begin m_hb = 0; m_p = 1'b1; end
        else begin m_hb = -1; m_p = 1'b0; end
      end
      return;
    end
    if (m_hb < 0 || m_hb == P - 1) begin
      if (rq) begin
        model_accept(len);
        return;
      end
      m_b = 1'b0;
      if (en) begin m_hb = 0; m_p = 1'b1; end
      else begin m_hb = -1; m_p = 1'b0; end
      return;
    end
    m_hb++;
    m_p = (m_hb < H);
    m_b = 1'b0;
  endfunction

  int  waited, nbusy, nhigh, nrise, nack, nidle;
  bit  prev;
  bit  req_acked;

  initial begin
    // ---- table fill ----
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(1, 1, 0, 0, (i % P) < H, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 1, 0, 0);
    for (int k = 3; k < P; k++) add(1, 0, 0, 0, k < H, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0, 0, 0);
    // zero-length burst from IDLE
    add(1, 0, 1, 0, 0, 1, 1);
    for (int k = 1; k < G; k++) add(1, 0, 0, 4'd9, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    // two-pulse burst from IDLE, stray request mid-burst, enable during gap
    add(1, 0, 1, 4'd2, 1, 1, 1);
    for (int k = 1; k < 2 * P + G; k++)
      add(1, k >= 25, (k >= 5 && k <= 8), 4'd7, (k < 2 * P) && ((k % P) < H), 0, 1);
    add(1, 1, 0, 0, 1, 0, 0);
    for (int k = 1; k < P; k++) add(1, 0, 0, 0, k < H, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; enable = tbl[i].en; burst_req = tbl[i].req; burst_len = tbl[i].len;
      tick();
      check($sformatf("tbl[%0d].pulse", i), pulse, tbl[i].p);
      check($sformatf("tbl[%0d].ack", i), burst_ack, tbl[i].a);
      check($sformatf("tbl[%0d].busy", i), busy, tbl[i].b);
    end

    // ---- burst requested mid-period during heartbeat ----
    do_reset();
    enable = 1'b1;
    repeat (3) tick();
    burst_req = 1'b1; burst_len = 4'd3;
    waited = 0;
    while (!burst_ack && waited < 30) begin tick(); waited++; end
    check("hb_ack_latency", waited, 8);
    burst_req = 1'b0; burst_len = 4'd0;
    nbusy = 0; nhigh = 0; nrise = 0; prev = 1'b0; waited = 0;
    while (busy && waited < 200) begin
      nbusy++;
      if (pulse) nhigh++;
      if (pulse && !prev) nrise++;
      prev = pulse;
      tick(); waited++;
    end
    check("hb_burst_busy_cycles", nbusy, 50);
    check("hb_burst_high_cycles", nhigh, 12);
    check("hb_burst_pulses", nrise, 3);
    check("hb_resume_pulse", pulse, 1);

    // ---- request held high, enable low ----
    do_reset();
    burst_req = 1'b1; burst_len = 4'd1;
    nack = 0; nrise = 0; nidle = 0; prev = 1'b0;
    repeat (100) begin
      tick();
      if (burst_ack) nack++;
      if (pulse && !prev) nrise++;
      if (!busy) nidle++;
      prev = pulse;
    end
    check("held_acks", nack, 4);
    check("held_bursts", nrise, 4);
    check("held_idle_passes", nidle, 3);
    burst_req = 1'b0;

    // ---- reset during the second pulse of a 5-pulse burst ----
    do_reset();
    burst_req = 1'b1; burst_len = 4'd5;
    tick();
    check("rst_mid_ack", burst_ack, 1);
    burst_req = 1'b0; burst_len = 4'd0;
    repeat (11) tick();
    check("rst_mid_second_pulse", pulse, 1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_pulse", pulse, 0);
    check("rst_mid_ack_low", burst_ack, 0);
    check("rst_mid_busy", busy, 0);
    rst_n = 1'b1;
    nhigh = 0; nbusy = 0;
    repeat (60) begin
      tick();
      if (pulse) nhigh++;
      if (busy) nbusy++;
    end
    check("rst_after_high", nhigh, 0);
    check("rst_after_busy", nbusy, 0);

    // ---- randomized run against the reference model ----
    rst_n = 1'b0; enable = 1'b0; burst_req = 1'b0; burst_len = 4'd0;
    model_step(rst_n, enable, burst_req, burst_len);
    tick();
    check("rnd_reset_pulse", pulse, m_p);
    req_acked = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if (!burst_req) begin
        if ($urandom_range(0, 39) == 0) burst_req = 1'b1;
      end else if ((req_acked && $urandom_range(0, 3) != 0) || $urandom_range(0, 199) == 0) begin
        burst_req = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) burst_len = 4'($urandom_range(0, 15));
      else burst_len = 4'($urandom_range(0, 3));
      model_step(rst_n, enable, burst_req, burst_len);
      tick();
      check($sformatf("rnd[%0d].pulse", c), pulse, m_p);
      check($sformatf("rnd[%0d].ack", c), burst_ack, m_a);
      check($sformatf("rnd[%0d].busy", c), busy, m_b);
      if (burst_ack) req_acked = 1'b1;
      if (!burst_req) req_acked = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Heartbeat/code pulse transmitter for the dual-core switch: drives a `pulse_a`/`pulse_b` line toward one CPU, the opposite end of the CPU-to-switch PWM heartbeat that `pulse_detection` monitors. It emits a continuous square-wave heartbeat while enabled. On a request/acknowledge handshake it instead sends a counted burst of pulses that encodes a status code, followed by a silent gap. One instance is built per CPU channel, next to the existing `pulse_detection` instances.

## Interface
- `PERIOD`, default 50000: cycles per pulse period, heartbeat and burst alike; legal range 2..2^CNT_W-1.
- `HIGH`, default 25000: high cycles per period; legal range 1..PERIOD-1.
- `GAP`, default 200000: low cycles after a burst; legal range 1..2^CNT_W-1.
- `CNT_W`, default 20: width of the period/gap counter.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `enable` in 1: level; heartbeat runs while 1.
- `burst_req` in 1: level; held high until `burst_ack`.
- `burst_len` in 4: number of code pulses, 0..15; sampled on the acceptance cycle.
- `burst_ack` out 1: one-cycle strobe on burst acceptance.
- `busy` out 1: high in BURST and GAP.
- `pulse` out 1: registered line output.

## Operation
- States: IDLE, HEART, BURST, GAP.
- `cnt` (CNT_W bits) runs 0..PERIOD-1 in HEART/BURST and 0..GAP-1 in GAP, then wraps to 0. `pcnt` (4 bits) counts burst pulses remaining.
- In HEART/BURST, next `pulse` = (next `cnt` < HIGH). In IDLE/GAP `pulse` = 0.
- IDLE:
  - `burst_req`=1 → accept, go to BURST.
  - else `enable`=1 → go to HEART with `cnt`=0 and `pulse`=1.
  - `burst_req` has priority over `enable`.
- HEART: at the wrap cycle (`cnt`=PERIOD-1):
  - `burst_req`=1 → accept, go to BURST.
  - else `enable`=0 → go to IDLE.
  - else stay in HEART.
  - Mid-period changes of `enable`/`burst_req` have no effect until the wrap, so no runt pulses are emitted.
- Acceptance:
  - `burst_ack`=1 for exactly that cycle; `burst_len` is latched into `pcnt`; `cnt`=0.
  - If `burst_len`=0, skip BURST and go straight to GAP (ack only, no pulses).
- BURST: full PERIOD/HIGH pulses; `pcnt` decrements at each wrap. At the wrap with `pcnt`=1, go to GAP.
- GAP: `pulse`=0 for GAP cycles, then:
  - `enable`=1 → HEART.
  - else → IDLE.
  - A `burst_req` still high at that point is not accepted until the next legal acceptance point. It is never accepted in BURST/GAP.
- `burst_len` is ignored outside the acceptance cycle.

## Timing
- All outputs registered. Reset values: `pulse`=0, `burst_ack`=0, `busy`=0, state IDLE, `cnt`=0, `pcnt`=0.
- `rst_n`=0 at any point, including mid-burst, returns every register to its reset value on the next edge. No partial burst resumes after reset.
- `enable` rise in IDLE → `pulse`=1 on the following edge (latency 1).
- Acceptance edge:
  - `burst_ack`=1 and `busy`=1 from this edge.
  - First burst pulse high in the same cycle (HEART wrap flows directly into BURST high time).
- Burst of N pulses occupies N·PERIOD cycles, then GAP cycles, then `busy`=0.
- `busy` falls on the same edge the state leaves GAP.
- Requester sees `burst_ack` and must drop `burst_req` within GAP cycles, or a second burst follows.

## Structure
- State encoding (IDLE/HEART/BURST/GAP) goes as localparams in the shared `uart_defines.v`-style include, `pulse_defines.v`, so `pulse_detection` and `command` can reference burst code lengths by name.
- Single flat module, no sub-module. Counter and FSM share one always block plus a registered output stage.

## Test plan
All scenarios use PERIOD=10, HIGH=4, GAP=20.
- Heartbeat start:
  - Stimulus: reset, then `enable`=1 held.
  - Required: `pulse` high 4 / low 6 repeating, first high 1 cycle after `enable`.
- Clean stop:
  - Stimulus: drop `enable` at cnt=2.
  - Required: the current period completes (4 high, 6 low), then `pulse` stays 0 and state is IDLE.
- Burst from heartbeat:
  - Stimulus: `burst_req`=1, `burst_len`=3 raised mid-period.
  - Required: `burst_ack` pulses at the wrap; exactly 3 pulses (30 cycles); 20 low; heartbeat resumes; `busy` high for 50 cycles.
- Zero length:
  - Stimulus: `burst_len`=0 from IDLE.
  - Required: `burst_ack` 1 cycle; `pulse` stays 0 for 20 cycles; `busy`=1 for 20 cycles.
- Held request:
  - Stimulus: `burst_req` never dropped, `enable`=0, `burst_len`=1.
  - Required: repeated 1-pulse bursts, each followed by 20 low cycles and an IDLE pass. `burst_ack` count equals burst count.
- Reset mid-burst:
  - Stimulus: `rst_n`=0 for 1 cycle during the second pulse of a 5-burst.
  - Required: all outputs 0 next cycle; no further pulses while `enable`=0 and `burst_req`=0.
